// File: rtl/alu_failover_ctrl_if.sv
// Bus for the ALU failover controller. It carries the per-result error flags in
// and the mux select, qualified valid and health status out.
interface alu_failover_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             valid;
    logic             err_a;
    logic             err_b;
    logic             clear;
    logic             s;
    logic             out_valid;
    logic             switch_pulse;
    logic             fault;
    logic [1:0]       state;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       switch_count;

    modport master (
        output valid, err_a, err_b, clear,
        input  s, out_valid, switch_pulse, fault, state, err_cnt, switch_count
    );

    modport slave (
        input  valid, err_a, err_b, clear,
        output s, out_valid, switch_pulse, fault, state, err_cnt, switch_count
    );
endinterface

// File: rtl/alu_failover_ctrl.sv
// Failover sequencer for the primary/spare ALU result mux. It counts consecutive
// errors on the active unit, switches to the spare, and declares a permanent fault.
module alu_failover_ctrl #(
    parameter int ERR_THRESH = 3,
    parameter int CNT_W      = 4,
    parameter int HOLDOFF    = 2
) (
    input logic                clk,
    input logic                rst_n,
    alu_failover_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        PRIMARY = 2'b00,
        SWITCH  = 2'b01,
        SPARE   = 2'b10,
        FAILED  = 2'b11
    } state_t;

    localparam int TMR_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [TMR_W-1:0] HOLD_INIT = TMR_W'(HOLDOFF - 1);

    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic             ov_q, ov_d;
    logic             pulse_q, pulse_d;
    logic             fault_q, fault_d;
    logic             spare_bad_q, spare_bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       swc_q, swc_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [CNT_W:0]   cnt_inc;
    logic             hit;
    logic [7:0]       swc_inc;

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign hit     = (cnt_inc == (CNT_W+1)'(ERR_THRESH));
    assign swc_inc = (swc_q == 8'hFF) ? swc_q : swc_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= PRIMARY;
            s_q         <= 1'b1;
            ov_q        <= 1'b0;
            pulse_q     <= 1'b0;
            fault_q     <= 1'b0;
            spare_bad_q <= 1'b0;
            cnt_q       <= '0;
            swc_q       <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            ov_q        <= ov_d;
            pulse_q     <= pulse_d;
            fault_q     <= fault_d;
            spare_bad_q <= spare_bad_d;
            cnt_q       <= cnt_d;
            swc_q       <= swc_d;
            tmr_q       <= tmr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        ov_d        = 1'b0;
        pulse_d     = 1'b0;
        fault_d     = fault_q;
        spare_bad_d = spare_bad_q;
        cnt_d       = cnt_q;
        swc_d       = swc_q;
        tmr_d       = tmr_q;

        if (bus.clear) begin
            state_d     = PRIMARY;
            s_d         = 1'b1;
            cnt_d       = '0;
            fault_d     = 1'b0;
            spare_bad_d = 1'b0;
            tmr_d       = '0;
        end else begin
            case (state_q)
                PRIMARY: begin
                    ov_d = bus.valid & ~bus.err_a;
                    if (bus.valid && bus.err_b) spare_bad_d = 1'b1;
                    if (bus.valid) begin
                        if (!bus.err_a) begin
                            cnt_d = '0;
                        end else if (hit) begin
                            // Spare health is judged on what was known before this result
                            cnt_d   = '0;
                            s_d     = 1'b0;
                            pulse_d = 1'b1;
                            swc_d   = swc_inc;
                            if (spare_bad_q) begin
                                state_d = FAILED;
                                fault_d = 1'b1;
                            end else begin
                                state_d = SWITCH;
                                tmr_d   = HOLD_INIT;
                            end
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                SWITCH: begin
                    cnt_d = '0;
                    if (tmr_q == '0) state_d = SPARE;
                    else             tmr_d   = tmr_q - 1'b1;
                end
                SPARE: begin
                    ov_d = bus.valid & ~bus.err_b;
                    if (bus.valid) begin
                        if (!bus.err_b) begin
                            cnt_d = '0;
                        end else if (hit) begin
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                            swc_d   = swc_inc;
                            state_d = FAILED;
                            fault_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                FAILED: begin
                    fault_d = 1'b1;
                end
                default: state_d = PRIMARY;
            endcase
        end
    end

    assign bus.s            = s_q;
    assign bus.out_valid    = ov_q;
    assign bus.switch_pulse = pulse_q;
    assign bus.fault        = fault_q;
    assign bus.state        = state_q;
    assign bus.err_cnt      = cnt_q;
    assign bus.switch_count = swc_q;
endmodule

// File: tb/tb_alu_failover_ctrl.sv
// Scoreboard bench: two controllers (threshold 3 / holdoff 2 and threshold 1 / holdoff 1)
// share one stimulus stream and are compared against a behavioural model every cycle.
module tb_alu_failover_ctrl;
    localparam int M_PRIMARY = 0;
    localparam int M_SWITCH  = 1;
    localparam int M_SPARE   = 2;
    localparam int M_FAILED  = 3;

    typedef struct {
        int mode;
        bit s;
        bit ov;
        bit pulse;
        bit fault;
        int cnt;
        int swc;
        bit spare_bad;
        int hold;
    } model_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_failover_ctrl_if #(.CNT_W(4)) bus_a ();
    alu_failover_ctrl_if #(.CNT_W(4)) bus_b ();

    alu_failover_ctrl #(.ERR_THRESH(3), .CNT_W(4), .HOLDOFF(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    alu_failover_ctrl #(.ERR_THRESH(1), .CNT_W(4), .HOLDOFF(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    model_t m_a, m_b;
    model_t q_a[$];
    model_t q_b[$];
    int checks = 0;
    int errors = 0;

    // Next-cycle outputs of the controller, derived from the behavioural rules
    function automatic model_t step(model_t m, bit r, bit v, bit ea, bit eb, bit clr,
                                    int thresh, int holdoff);
        model_t n;
        bit     act_err;
        n = m;
        n.pulse = 0;
        n.ov    = 0;
        if (!r) begin
            n = '{M_PRIMARY, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0};
            return n;
        end
        if (clr) begin
            n.mode = M_PRIMARY; n.s = 1; n.cnt = 0; n.fault = 0; n.spare_bad = 0; n.hold = 0;
            return n;
        end
        if (m.mode == M_SWITCH) begin
            n.cnt = 0;
            if (m.hold == 0) n.mode = M_SPARE;
            else             n.hold = m.hold - 1;
        end else if (m.mode == M_PRIMARY || m.mode == M_SPARE) begin
            act_err = (m.mode == M_PRIMARY) ? ea : eb;
            n.ov = v && !act_err;
            if (m.mode == M_PRIMARY && v && eb) n.spare_bad = 1;
            if (v && !act_err) n.cnt = 0;
            if (v && act_err) begin
                if (m.cnt + 1 >= thresh) begin
                    n.cnt   = 0;
                    n.s     = 0;
                    n.pulse = 1;
                    n.swc   = (m.swc >= 255) ? 255 : m.swc + 1;
                    if (m.mode == M_SPARE || m.spare_bad) begin
                        n.mode  = M_FAILED;
                        n.fault = 1;
                    end else begin
                        n.mode = M_SWITCH;
                        n.hold = holdoff - 1;
                    end
                end else begin
                    n.cnt = m.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    task automatic apply_stimulus(input bit r, input bit v, input bit ea, input bit eb,
                                  input bit clr);
        @(negedge clk);
        #2;
        rst_n       = r;
        bus_a.valid = v;  bus_a.err_a = ea; bus_a.err_b = eb; bus_a.clear = clr;
        bus_b.valid = v;  bus_b.err_a = ea; bus_b.err_b = eb; bus_b.clear = clr;
        m_a = step(m_a, r, v, ea, eb, clr, 3, 2);
        m_b = step(m_b, r, v, ea, eb, clr, 1, 1);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input int exp);
        checks++;
        if (act !== 8'(exp)) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input model_t e, input logic [1:0] st,
                                input logic s, input logic ov, input logic pulse,
                                input logic fault, input logic [3:0] cnt,
                                input logic [7:0] swc);
        cmp({tag, " state"}, {6'd0, st}, e.mode);
        cmp({tag, " s"}, {7'd0, s}, int'(e.s));
        cmp({tag, " out_valid"}, {7'd0, ov}, int'(e.ov));
        cmp({tag, " switch_pulse"}, {7'd0, pulse}, int'(e.pulse));
        cmp({tag, " fault"}, {7'd0, fault}, int'(e.fault));
        cmp({tag, " err_cnt"}, {4'd0, cnt}, e.cnt);
        cmp({tag, " switch_count"}, swc, e.swc);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q_a.size() > 0)
            check_output("A", q_a.pop_front(), bus_a.state, bus_a.s, bus_a.out_valid,
                         bus_a.switch_pulse, bus_a.fault, bus_a.err_cnt, bus_a.switch_count);
        if (q_b.size() > 0)
            check_output("B", q_b.pop_front(), bus_b.state, bus_b.s, bus_b.out_valid,
                         bus_b.switch_pulse, bus_b.fault, bus_b.err_cnt, bus_b.switch_count);
    end

    initial begin
        bus_a.valid = 0; bus_a.err_a = 0; bus_a.err_b = 0; bus_a.clear = 0;
        bus_b.valid = 0; bus_b.err_a = 0; bus_b.err_b = 0; bus_b.clear = 0;
        m_a = '{M_PRIMARY, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0};
        m_b = m_a;

        repeat (2) apply_stimulus(0, 0, 0, 0, 0);
        repeat (4) apply_stimulus(1, 1, 0, 0, 0);
        apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0);
        apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0);
        repeat (3) apply_stimulus(1, 1, 1, 0, 0);
        repeat (3) apply_stimulus(1, 0, 0, 0, 0);
        repeat (2) apply_stimulus(1, 1, 0, 0, 0);
        repeat (3) apply_stimulus(1, 1, 0, 1, 0);
        repeat (2) apply_stimulus(1, 1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1);
        apply_stimulus(1, 1, 0, 1, 0);
        repeat (3) apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1);
        repeat (2) apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(1, 1, 1, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0);
        repeat (3) apply_stimulus(1, 1, 1, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(($urandom_range(0, 99) != 0),
                           ($urandom_range(0, 9) < 7),
                           ($urandom_range(0, 9) < 4),
                           ($urandom_range(0, 9) < 3),
                           ($urandom_range(0, 29) == 0));
        end

        for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
            @(posedge clk);
            #3;
        end
        checks++;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", q_a.size() + q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
